// File: rtl/rr_engine_scheduler_pkg.sv
// Shared types for the round-robin engine scheduler: FSM state encoding and
// a helper for sizing requester-index fields.
package rr_engine_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_GRANT = 2'b01,
      S_WAIT  = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   // A single requester still needs a 1-bit index field.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_engine_scheduler_priority_pick.sv
// Combinational round-robin pick: first set request at or after i_ptr,
// searching upward with wrap-around.
module rr_priority_pick
   import rr_engine_scheduler_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_pick,
   output logic [IDX_W-1:0] o_idx
);

   logic w_found;
   int   w_j;

   always_comb begin
      o_pick  = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = (int'(i_ptr) + k) % N_REQ;
         if (!w_found && i_req[w_j]) begin
            w_found     = 1'b1;
            o_pick[w_j] = 1'b1;
            o_idx       = IDX_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/rr_engine_scheduler.sv
// Shares one start/done engine among N_REQ requesters: round-robin pick,
// start pulse, wait for done or watchdog expiry, ack the owner, rotate priority.
module rr_engine_scheduler
   import rr_engine_scheduler_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_engine_done,
   output logic             o_engine_start,
   output logic [N_REQ-1:0] o_grant,
   output logic [N_REQ-1:0] o_ack,
   output logic             o_error,
   output logic             o_busy
);

   localparam int IDX_W = idx_width(N_REQ);
   localparam logic [TO_W-1:0]  WD_MAX  = '1;
   localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N_REQ - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [N_REQ-1:0] r_winner;
   logic [IDX_W-1:0] r_win_idx;
   logic [TO_W-1:0]  r_wdog;
   logic             r_error;

   logic [N_REQ-1:0] w_pick;
   logic [IDX_W-1:0] w_pick_idx;

   rr_priority_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .i_req  (i_req),
      .i_ptr  (r_ptr),
      .o_pick (w_pick),
      .o_idx  (w_pick_idx)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_winner  <= '0;
         r_win_idx <= '0;
         r_wdog    <= '0;
         r_error   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|i_req) begin
                  r_winner  <= w_pick;
                  r_win_idx <= w_pick_idx;
                  r_state   <= S_GRANT;
               end
            end
            S_GRANT: begin
               r_wdog  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wdog != WD_MAX)
                  r_wdog <= r_wdog + 1'b1;
               // Done takes precedence over a simultaneous watchdog expiry.
               if (i_engine_done) begin
                  r_error <= 1'b0;
                  r_state <= S_DONE;
               end else if (r_wdog == WD_LAST) begin
                  r_error <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_ptr   <= (r_win_idx == IDX_TOP) ? '0 : r_win_idx + 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Moore decode from state and latched winner; async reset clears all at once.
   assign o_busy         = (r_state != S_IDLE);
   assign o_engine_start = (r_state == S_GRANT);
   assign o_grant        = (r_state == S_IDLE) ? '0 : r_winner;
   assign o_ack          = (r_state == S_DONE) ? r_winner : '0;
   assign o_error        = (r_state == S_DONE) && r_error;

endmodule

// File: doc/rr_engine_scheduler.md
Name: rr_engine_scheduler

Overview:
- Shares one start/done processing engine among N_REQ requesters. The engine is any block with an i_start / i_done_condition style interface.
- Picks one requester by round-robin arbitration, pulses the engine start, and waits for engine done or a watchdog timeout.
- Acknowledges the winner, then advances the priority pointer.
- Sits between requester logic and the single engine instance in the top-level datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 1000, maximum S_WAIT cycles before a job is aborted (>= 2).
- TO_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived; not overridden).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  level request per requester; held until matching o_ack.
- i_engine_done  in  1  single-cycle done pulse from the engine.
- o_engine_start  out  1  single-cycle start pulse to the engine.
- o_grant  out  N_REQ  one-hot owner of the engine; zero when idle.
- o_ack  out  N_REQ  one-hot single-cycle completion pulse to the owner.
- o_error  out  1  high with o_ack when the job ended by timeout.
- o_busy  out  1  high in any state other than S_IDLE.

Behaviour:
- Reset (asynchronous, takes effect with no clock edge):
  - state = S_IDLE; priority pointer = 0; watchdog = 0; winner register = 0.
  - All outputs are 0.
  - Reset in mid-job abandons the job: no ack and no error are issued. The engine is reset by the same i_reset.
- Four states, all outputs Moore-decoded from state plus the registered winner:
  - S_IDLE: if i_req != 0, latch the round-robin winner and go to S_GRANT. Otherwise stay.
  - S_GRANT: exactly 1 cycle. o_engine_start = 1 and o_grant = winner. Clear the watchdog, then go to S_WAIT.
  - S_WAIT: o_grant = winner; the watchdog increments each cycle.
    - If i_engine_done = 1, go to S_DONE with error flag 0.
    - Else, if the watchdog equals TIMEOUT_CYCLES-1, go to S_DONE with error flag 1.
    - Done and expiry in the same cycle: done wins, error flag 0.
  - S_DONE: exactly 1 cycle. o_ack = winner, o_grant = winner, o_error = error flag. Pointer = (winner index + 1) mod N_REQ, then go to S_IDLE.
  - Unreachable encodings go to S_IDLE.
- Round-robin arbitration:
  - Search begins at the pointer index and ascends with wrap-around. The first set bit wins.
  - Pointer 0 and requests 4'b1010 gives a grant to index 1. After that job the pointer is 2, so with 4'b1010 still requesting the grant goes to index 3.
- Latency:
  - A request sampled at edge k gives o_engine_start high in cycle k+1. The minimum job is 3 cycles (GRANT, WAIT with done, DONE).
  - The next grant can start 1 cycle after S_DONE; the IDLE cycle is mandatory.
- i_engine_done outside S_WAIT is ignored. A requester that deasserts i_req mid-job does not cancel the job; it still receives o_ack.
- A requester still asserting i_req on the cycle after its ack is treated as a new request, subject to the rotated priority.
- Watchdog: saturating, TO_W bits wide, and reset only in S_GRANT or by i_reset.
- o_grant is always one-hot or zero. o_ack and o_engine_start are never high for more than 1 consecutive cycle.

Decomposition:
- Shared package/header: state localparams S_IDLE=2'b00, S_GRANT=2'b01, S_WAIT=2'b10, S_DONE=2'b11.
- One sub-module, rr_priority_pick: a purely combinational (i_req, i_ptr) -> one-hot o_pick plus index, parameterised by N_REQ.
- The scheduler holds the state register, next-state logic, output decode, pointer, and watchdog.

Test Plan:
1. Reset with i_req=4'b0001 pending, then release; engine pulses done 5 cycles after start.
   - Required: start 1 cycle after release sample, o_grant=4'b0001 through the ack.
   - Required: o_ack=4'b0001 for 1 cycle, o_error=0, o_busy low the next cycle.
2. Hold i_req=4'b1111 for 4 jobs, each done after 2 WAIT cycles.
   - Required: grants in order 0,1,2,3; pointer wraps to 0; every job 5 cycles including IDLE.
3. TIMEOUT_CYCLES=8; i_req=4'b0100; never pulse done.
   - Required: exactly 8 S_WAIT cycles, then o_ack=4'b0100 with o_error=1, then o_busy=0.
4. TIMEOUT_CYCLES=8; pulse done on the 8th WAIT cycle (watchdog=7).
   - Required: o_error=0, the done path is taken.
5. Assert i_reset asynchronously mid-S_WAIT, between clock edges.
   - Required: o_grant, o_busy and o_engine_start drop to 0 before the next edge; no o_ack afterwards; pointer=0.
6. Pulse done during S_IDLE and S_GRANT, and drop i_req mid-job.
   - Required: the stray done pulses are ignored; the dropped requester still gets o_ack.
